// File: rtl/uart_matrix_cmd_parser.sv
// rtl/uart_matrix_cmd_parser.sv - ASCII decimal command parser feeding matrix storage and operation control.
// Define PARSER_SIGNED_EN to accept a leading '-' on element and scalar tokens (two's complement).
module uart_matrix_cmd_parser #(
    parameter int DATA_W  = 8,
    parameter int DIM_W   = 3,
    parameter int MAX_DIM = 5,
    parameter int ID_W    = 4,
    parameter int NUM_OPS = 2,
    parameter int CNT_W   = 4,
    parameter int IDX_W   = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    input  logic                    start,
    input  logic [1:0]              mode_sel,
    output logic                    busy,
    output logic [DIM_W-1:0]        dim_m,
    output logic [DIM_W-1:0]        dim_n,
    output logic [DATA_W-1:0]       elem_data,
    output logic [IDX_W-1:0]        elem_idx,
    output logic                    elem_we,
    output logic [CNT_W-1:0]        gen_count,
    output logic [NUM_OPS*ID_W-1:0] op_ids,
    output logic                    done,
    output logic                    err,
    output logic [1:0]              err_code
);

    localparam int ACC_W  = DATA_W + 4;
    localparam int MUL_W  = ACC_W + 4;
    localparam int SLOT_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

`ifdef PARSER_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    localparam logic [MUL_W-1:0] U_MAX   = MUL_W'({DATA_W{1'b1}});
    localparam logic [ACC_W-1:0] POS_MAX = ACC_W'({(DATA_W-1){1'b1}});
    localparam logic [ACC_W-1:0] NEG_MAX = ACC_W'(1) << (DATA_W - 1);
    localparam logic [ACC_W-1:0] DIM_LIM = ACC_W'(MAX_DIM);
    localparam logic [ACC_W-1:0] ID_LIM  = ACC_W'(1) << ID_W;

    localparam logic [1:0] MODE_INPUT = 2'b00;
    localparam logic [1:0] MODE_GEN   = 2'b01;
    localparam logic [1:0] MODE_SEL   = 2'b10;

    localparam logic [1:0] EC_ILLEGAL  = 2'd0;
    localparam logic [1:0] EC_OVERFLOW = 2'd1;
    localparam logic [1:0] EC_BAD_ARG  = 2'd2;
    localparam logic [1:0] EC_ABORT    = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DIM_M,
        S_DIM_N,
        S_ELEMS,
        S_COUNT,
        S_IDS,
        S_SCALAR,
        S_DONE,
        S_ERR
    } state_t;

    state_t                    state, state_d;
    logic [1:0]                mode, mode_d;
    logic [ACC_W-1:0]          acc, acc_d;
    logic                      ovf, ovf_d;
    logic                      have_dig, have_dig_d;
    logic                      neg, neg_d;
    logic [IDX_W-1:0]          elem_cnt, elem_cnt_d;
    logic [SLOT_W-1:0]         slot, slot_d;

    logic                      busy_d;
    logic [DIM_W-1:0]          dim_m_d, dim_n_d;
    logic [DATA_W-1:0]         elem_data_d;
    logic [IDX_W-1:0]          elem_idx_d;
    logic                      elem_we_d;
    logic [CNT_W-1:0]          gen_count_d;
    logic [NUM_OPS*ID_W-1:0]   op_ids_d;
    logic                      done_d, err_d;
    logic [1:0]                err_code_d;

    logic                      is_digit, is_sep, is_esc, is_minus;
    logic [MUL_W-1:0]          acc_mul;
    logic [DATA_W-1:0]         elem_val;
    logic                      elem_fits, dim_ok;
    logic [IDX_W-1:0]          elem_last;
    logic                      fail;
    logic [1:0]                fail_code;

    always_comb begin
        is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        is_sep    = (rx_data == 8'h20) || (rx_data == 8'h0D) ||
                    (rx_data == 8'h0A) || (rx_data == 8'h2C);
        is_esc    = (rx_data == 8'h1B);
        is_minus  = (rx_data == 8'h2D);
        acc_mul   = MUL_W'(acc) * MUL_W'(10) + MUL_W'(rx_data[3:0]);
        elem_val  = neg ? (DATA_W'(0) - acc[DATA_W-1:0]) : acc[DATA_W-1:0];
        // Sticky ovf already covers the unsigned range; signed entry narrows it further.
        elem_fits = !ovf && (!SIGNED_EN || (neg ? (acc <= NEG_MAX) : (acc <= POS_MAX)));
        dim_ok    = (acc != '0) && (acc <= DIM_LIM);
        elem_last = IDX_W'(int'(dim_m) * int'(dim_n) - 1);

        state_d     = state;
        mode_d      = mode;
        acc_d       = acc;
        ovf_d       = ovf;
        have_dig_d  = have_dig;
        neg_d       = neg;
        elem_cnt_d  = elem_cnt;
        slot_d      = slot;
        dim_m_d     = dim_m;
        dim_n_d     = dim_n;
        elem_data_d = elem_data;
        elem_idx_d  = elem_idx;
        elem_we_d   = 1'b0;
        gen_count_d = gen_count;
        op_ids_d    = op_ids;
        done_d      = (state == S_DONE);
        err_d       = (state == S_ERR);
        err_code_d  = err_code;
        fail        = 1'b0;
        fail_code   = EC_ILLEGAL;

        case (state)
            S_IDLE: begin
                acc_d      = '0;
                ovf_d      = 1'b0;
                have_dig_d = 1'b0;
                neg_d      = 1'b0;
                if (start && !busy) begin
                    mode_d     = mode_sel;
                    elem_cnt_d = '0;
                    slot_d     = '0;
                    case (mode_sel)
                        MODE_INPUT, MODE_GEN: state_d = S_DIM_M;
                        MODE_SEL:             state_d = S_IDS;
                        default:              state_d = S_SCALAR;
                    endcase
                end
            end

            S_DONE, S_ERR: begin
                state_d    = S_IDLE;
                acc_d      = '0;
                ovf_d      = 1'b0;
                have_dig_d = 1'b0;
                neg_d      = 1'b0;
            end

            default: begin
                if (rx_valid) begin
                    if (is_esc) begin
                        fail      = 1'b1;
                        fail_code = EC_ABORT;
                    end else if (is_digit) begin
                        acc_d      = acc_mul[ACC_W-1:0];
                        ovf_d      = ovf || (acc_mul > U_MAX);
                        have_dig_d = 1'b1;
                    end else if (is_minus && SIGNED_EN && !have_dig && !neg &&
                                 (state == S_ELEMS || state == S_SCALAR)) begin
                        neg_d = 1'b1;
                    end else if (is_sep && !have_dig) begin
                        // Empty separator runs are skipped; a lone '-' is not a token.
                        if (neg) begin
                            fail      = 1'b1;
                            fail_code = EC_ILLEGAL;
                        end
                    end else if (is_sep) begin
                        acc_d      = '0;
                        ovf_d      = 1'b0;
                        have_dig_d = 1'b0;
                        neg_d      = 1'b0;
                        case (state)
                            S_DIM_M, S_DIM_N: begin
                                if (ovf) begin
                                    fail      = 1'b1;
                                    fail_code = EC_OVERFLOW;
                                end else if (!dim_ok) begin
                                    fail      = 1'b1;
                                    fail_code = EC_BAD_ARG;
                                end else if (state == S_DIM_M) begin
                                    dim_m_d = acc[DIM_W-1:0];
                                    state_d = S_DIM_N;
                                end else begin
                                    dim_n_d = acc[DIM_W-1:0];
                                    state_d = (mode == MODE_INPUT) ? S_ELEMS : S_COUNT;
                                end
                            end
                            S_ELEMS, S_SCALAR: begin
                                if (!elem_fits) begin
                                    fail      = 1'b1;
                                    fail_code = EC_OVERFLOW;
                                end else begin
                                    elem_data_d = elem_val;
                                    elem_we_d   = 1'b1;
                                    if (state == S_SCALAR) begin
                                        elem_idx_d = '0;
                                        state_d    = S_DONE;
                                    end else begin
                                        elem_idx_d = elem_cnt;
                                        elem_cnt_d = elem_cnt + 1'b1;
                                        if (elem_cnt == elem_last) state_d = S_DONE;
                                    end
                                end
                            end
                            S_COUNT: begin
                                if (ovf) begin
                                    fail      = 1'b1;
                                    fail_code = EC_OVERFLOW;
                                end else begin
                                    gen_count_d = acc[CNT_W-1:0];
                                    state_d     = S_DONE;
                                end
                            end
                            default: begin
                                if (ovf) begin
                                    fail      = 1'b1;
                                    fail_code = EC_OVERFLOW;
                                end else if (acc >= ID_LIM) begin
                                    fail      = 1'b1;
                                    fail_code = EC_BAD_ARG;
                                end else begin
                                    op_ids_d[int'(slot)*ID_W +: ID_W] = acc[ID_W-1:0];
                                    slot_d = slot + 1'b1;
                                    if (slot == SLOT_W'(NUM_OPS - 1)) state_d = S_DONE;
                                end
                            end
                        endcase
                    end else begin
                        fail      = 1'b1;
                        fail_code = EC_ILLEGAL;
                    end
                end
            end
        endcase

        if (fail) begin
            state_d    = S_ERR;
            err_code_d = fail_code;
            acc_d      = '0;
            ovf_d      = 1'b0;
            have_dig_d = 1'b0;
            neg_d      = 1'b0;
        end

        // Busy stays up through the done/err pulse so a start in that cycle is ignored.
        busy_d = (state_d != S_IDLE) || (state == S_DONE) || (state == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mode      <= 2'b00;
            acc       <= '0;
            ovf       <= 1'b0;
            have_dig  <= 1'b0;
            neg       <= 1'b0;
            elem_cnt  <= '0;
            slot      <= '0;
            busy      <= 1'b0;
            dim_m     <= '0;
            dim_n     <= '0;
            elem_data <= '0;
            elem_idx  <= '0;
            elem_we   <= 1'b0;
            gen_count <= '0;
            op_ids    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            state     <= state_d;
            mode      <= mode_d;
            acc       <= acc_d;
            ovf       <= ovf_d;
            have_dig  <= have_dig_d;
            neg       <= neg_d;
            elem_cnt  <= elem_cnt_d;
            slot      <= slot_d;
            busy      <= busy_d;
            dim_m     <= dim_m_d;
            dim_n     <= dim_n_d;
            elem_data <= elem_data_d;
            elem_idx  <= elem_idx_d;
            elem_we   <= elem_we_d;
            gen_count <= gen_count_d;
            op_ids    <= op_ids_d;
            done      <= done_d;
            err       <= err_d;
            err_code  <= err_code_d;
        end
    end

endmodule

// File: tb/tb_uart_matrix_cmd_parser.sv
// tb/tb_uart_matrix_cmd_parser.sv - directed self-checking bench for uart_matrix_cmd_parser.
module tb_uart_matrix_cmd_parser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode_sel = 2'b00;
    logic       busy;
    logic [2:0] dim_m, dim_n;
    logic [7:0] elem_data;
    logic [4:0] elem_idx;
    logic       elem_we;
    logic [3:0] gen_count;
    logic [7:0] op_ids;
    logic       done, err;
    logic [1:0] err_code;

    int n_cmp = 0;
    int n_bad = 0;

    int         we_n = 0;
    int         done_n = 0;
    int         err_n = 0;
    logic [7:0] we_data [0:63];
    logic [4:0] we_idx  [0:63];
    logic [1:0] last_code = 2'b00;

    int we0, d0, e0;

    uart_matrix_cmd_parser #(
        .DATA_W(8), .DIM_W(3), .MAX_DIM(5), .ID_W(4),
        .NUM_OPS(2), .CNT_W(4), .IDX_W(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .start(start), .mode_sel(mode_sel), .busy(busy),
        .dim_m(dim_m), .dim_n(dim_n), .elem_data(elem_data), .elem_idx(elem_idx),
        .elem_we(elem_we), .gen_count(gen_count), .op_ids(op_ids),
        .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (elem_we) begin
            if (we_n < 64) begin
                we_data[we_n] = elem_data;
                we_idx[we_n]  = elem_idx;
            end
            we_n = we_n + 1;
        end
        if (done) done_n = done_n + 1;
        if (err) begin
            err_n = err_n + 1;
            last_code = err_code;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic snap;
        we0 = we_n;
        d0  = done_n;
        e0  = err_n;
    endtask

    task automatic do_start(input logic [1:0] m);
        int t = 0;
        while (busy !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL start_wait busy=%b required 0", busy);
        end
        @(negedge clk);
        start = 1'b1;
        mode_sel = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            rx_data  = s[i];
            rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_idle;
        int t = 0;
        @(negedge clk);
        while (busy !== 1'b0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_wait busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset;
        #3;
        n_cmp++;
        if ({busy, dim_m, dim_n, elem_data, elem_idx, elem_we, gen_count, op_ids, done, err, err_code} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got busy=%b dm=%0d dn=%0d ed=%h ei=%0d we=%b gc=%0d ids=%h d=%b e=%b ec=%0d required all 0",
                     busy, dim_m, dim_n, elem_data, elem_idx, elem_we, gen_count, op_ids, done, err, err_code);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release busy=%b done=%b err=%b required 0 0 0", busy, done, err);
        end
    endtask

    task automatic test_matrix_input;
        snap();
        do_start(2'b00);
        send_str("2 3 1 2 3 4 5 6\015");
        n_cmp++;
        if (elem_we !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL last_elem_cycle we=%b done=%b required 1 0", elem_we, done);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL done_timing done=%b busy=%b required 1 1", done, busy);
        end
        wait_idle();
        n_cmp++;
        if (we_n - we0 !== 6) begin
            n_bad++;
            $display("FAIL input_we_count got %0d required 6", we_n - we0);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (we_data[we0+i] !== 8'(i + 1) || we_idx[we0+i] !== 5'(i)) begin
                n_bad++;
                $display("FAIL input_elem%0d data=%0d idx=%0d required %0d %0d",
                         i, we_data[we0+i], we_idx[we0+i], i + 1, i);
            end
        end
        n_cmp++;
        if (dim_m !== 3'd2 || dim_n !== 3'd3) begin
            n_bad++;
            $display("FAIL input_dims got %0dx%0d required 2x3", dim_m, dim_n);
        end
        n_cmp++;
        if (done_n - d0 !== 1 || err_n - e0 !== 0) begin
            n_bad++;
            $display("FAIL input_pulses done=%0d err=%0d required 1 0", done_n - d0, err_n - e0);
        end
    endtask

    task automatic test_gen;
        snap();
        do_start(2'b01);
        send_str("3  4\015\0122 ");
        wait_idle();
        n_cmp++;
        if (dim_m !== 3'd3 || dim_n !== 3'd4 || gen_count !== 4'd2) begin
            n_bad++;
            $display("FAIL gen_values got m=%0d n=%0d cnt=%0d required 3 4 2", dim_m, dim_n, gen_count);
        end
        n_cmp++;
        if (done_n - d0 !== 1 || err_n - e0 !== 0 || we_n - we0 !== 0) begin
            n_bad++;
            $display("FAIL gen_pulses done=%0d err=%0d we=%0d required 1 0 0", done_n - d0, err_n - e0, we_n - we0);
        end
    endtask

    task automatic test_select;
        snap();
        do_start(2'b10);
        send_str("7,12 ");
        wait_idle();
        n_cmp++;
        if (op_ids !== 8'hC7 || done_n - d0 !== 1) begin
            n_bad++;
            $display("FAIL select_ids got %h done=%0d required c7 1", op_ids, done_n - d0);
        end
        snap();
        do_start(2'b10);
        send_str("16 ");
        wait_idle();
        n_cmp++;
        if (err_n - e0 !== 1 || last_code !== 2'd2 || err_code !== 2'd2) begin
            n_bad++;
            $display("FAIL select_bad_id err=%0d code=%0d required 1 2", err_n - e0, last_code);
        end
        n_cmp++;
        if (op_ids !== 8'hC7 || done_n - d0 !== 0) begin
            n_bad++;
            $display("FAIL select_ids_kept got %h done=%0d required c7 0", op_ids, done_n - d0);
        end
    endtask

    task automatic test_bad_dim;
        snap();
        do_start(2'b00);
        send_str("6 2 ");
        wait_idle();
        n_cmp++;
        if (err_n - e0 !== 1 || last_code !== 2'd2 || dim_m !== 3'd3) begin
            n_bad++;
            $display("FAIL dim_too_big err=%0d code=%0d dim_m=%0d required 1 2 3", err_n - e0, last_code, dim_m);
        end
        snap();
        do_start(2'b00);
        send_str("5 0 ");
        wait_idle();
        n_cmp++;
        if (err_n - e0 !== 1 || last_code !== 2'd2 || dim_m !== 3'd5 || dim_n !== 3'd4) begin
            n_bad++;
            $display("FAIL dim_zero err=%0d code=%0d m=%0d n=%0d required 1 2 5 4",
                     err_n - e0, last_code, dim_m, dim_n);
        end
    endtask

    task automatic test_scalar;
        snap();
        do_start(2'b11);
        send_str("255 ");
        wait_idle();
        n_cmp++;
        if (we_n - we0 !== 1 || we_data[we0] !== 8'hFF || we_idx[we0] !== 5'd0 || done_n - d0 !== 1) begin
            n_bad++;
            $display("FAIL scalar_max we=%0d data=%h idx=%0d done=%0d required 1 ff 0 1",
                     we_n - we0, we_data[we0], we_idx[we0], done_n - d0);
        end
        snap();
        do_start(2'b11);
        send_str("300 ");
        wait_idle();
        n_cmp++;
        if (err_n - e0 !== 1 || last_code !== 2'd1 || we_n - we0 !== 0) begin
            n_bad++;
            $display("FAIL scalar_overflow err=%0d code=%0d we=%0d required 1 1 0", err_n - e0, last_code, we_n - we0);
        end
    endtask

    task automatic test_abort;
        snap();
        do_start(2'b00);
        send_str("2 2 5 \033");
        wait_idle();
        n_cmp++;
        if (we_n - we0 !== 1 || we_data[we0] !== 8'd5 || we_idx[we0] !== 5'd0) begin
            n_bad++;
            $display("FAIL abort_elem we=%0d data=%0d idx=%0d required 1 5 0", we_n - we0, we_data[we0], we_idx[we0]);
        end
        n_cmp++;
        if (err_n - e0 !== 1 || last_code !== 2'd3 || dim_m !== 3'd2 || dim_n !== 3'd2) begin
            n_bad++;
            $display("FAIL abort_err err=%0d code=%0d m=%0d n=%0d required 1 3 2 2",
                     err_n - e0, last_code, dim_m, dim_n);
        end
        snap();
        do_start(2'b11);
        send_str("9 ");
        wait_idle();
        n_cmp++;
        if (done_n - d0 !== 1 || we_n - we0 !== 1 || we_data[we0] !== 8'd9) begin
            n_bad++;
            $display("FAIL abort_restart done=%0d we=%0d data=%0d required 1 1 9", done_n - d0, we_n - we0, we_data[we0]);
        end
    endtask

    task automatic test_illegal;
        snap();
        do_start(2'b11);
        send_str("1a ");
        wait_idle();
        n_cmp++;
        if (err_n - e0 !== 1 || last_code !== 2'd0 || we_n - we0 !== 0) begin
            n_bad++;
            $display("FAIL illegal_char err=%0d code=%0d we=%0d required 1 0 0", err_n - e0, last_code, we_n - we0);
        end
    endtask

    task automatic test_minus;
`ifdef PARSER_SIGNED_EN
        snap();
        do_start(2'b11);
        send_str("-128 ");
        wait_idle();
        n_cmp++;
        if (done_n - d0 !== 1 || we_n - we0 !== 1 || we_data[we0] !== 8'h80) begin
            n_bad++;
            $display("FAIL signed_min done=%0d we=%0d data=%h required 1 1 80", done_n - d0, we_n - we0, we_data[we0]);
        end
        snap();
        do_start(2'b11);
        send_str("-129 ");
        wait_idle();
        n_cmp++;
        if (err_n - e0 !== 1 || last_code !== 2'd1) begin
            n_bad++;
            $display("FAIL signed_overflow err=%0d code=%0d required 1 1", err_n - e0, last_code);
        end
        snap();
        do_start(2'b11);
        send_str("5-3 ");
        wait_idle();
        n_cmp++;
        if (err_n - e0 !== 1 || last_code !== 2'd0) begin
            n_bad++;
            $display("FAIL signed_mid_minus err=%0d code=%0d required 1 0", err_n - e0, last_code);
        end
`else
        snap();
        do_start(2'b11);
        send_str("-5 ");
        wait_idle();
        n_cmp++;
        if (err_n - e0 !== 1 || last_code !== 2'd0 || we_n - we0 !== 0) begin
            n_bad++;
            $display("FAIL unsigned_minus err=%0d code=%0d we=%0d required 1 0 0", err_n - e0, last_code, we_n - we0);
        end
`endif
    endtask

    task automatic test_async_reset;
        do_start(2'b00);
        send_str("4 ");
        n_cmp++;
        if (dim_m !== 3'd4 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset dim_m=%0d busy=%b required 4 1", dim_m, busy);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dim_m !== 3'd0 || dim_n !== 3'd0 || busy !== 1'b0 || op_ids !== 8'h00 || err_code !== 2'd0) begin
            n_bad++;
            $display("FAIL async_reset dm=%0d dn=%0d busy=%b ids=%h ec=%0d required 0 0 0 00 0",
                     dim_m, dim_n, busy, op_ids, err_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_matrix_input();
        test_gen();
        test_select();
        test_bad_dim();
        test_scalar();
        test_abort();
        test_illegal();
        test_minus();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_matrix_cmd_parser.md
# uart_matrix_cmd_parser

Parametrised ASCII command parser between the UART receiver and the matrix storage / operation controller. It tokenises decimal numbers from the RX byte stream and runs one of four command modes: matrix input, matrix generation, operand selection, or scalar entry. It replaces the fixed 8-bit / 3-bit parser with configurable widths, streaming element writes with an index, error reporting, and an abort character.

## Interface
- DATA_W, 8: element / scalar width.
- DIM_W, 3: dimension field width.
- MAX_DIM, 5: largest legal m or n.
- ID_W, 4: matrix ID width.
- NUM_OPS, 2: operand IDs collected in select mode (1..4).
- CNT_W, 4: generation count width.
- IDX_W, 5: element index width; must hold MAX_DIM*MAX_DIM-1.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- start  in  1  pulse; begins a command. Ignored while busy.
- mode_sel  in  2  sampled on start: 00 input, 01 gen, 10 select, 11 scalar.
- busy  out  1  high from the cycle after start until the cycle after done/err.
- dim_m, dim_n  out  DIM_W  committed dimensions.
- elem_data  out  DATA_W  element or scalar value.
- elem_idx  out  IDX_W  row-major index of elem_data.
- elem_we  out  1  one-cycle element write strobe.
- gen_count  out  CNT_W  count parsed in gen mode.
- op_ids  out  NUM_OPS*ID_W  operand IDs, op 0 in the LSBs.
- done  out  1  one-cycle command-complete pulse.
- err  out  1  one-cycle error pulse.
- err_code  out  2  0 illegal char, 1 overflow, 2 bad dim/ID, 3 abort. Held until the next err.

All outputs reset to 0.

## Operation
- States: IDLE, DIM_M, DIM_N, ELEMS, COUNT, IDS, SCALAR, DONE, ERR.
- From IDLE, start moves to DIM_M for modes 00 and 01, IDS for 10, and SCALAR for 11. rx_valid is ignored in IDLE.
- Digits '0'..'9' update the accumulator: acc = acc*10 + digit. The accumulator is DATA_W+4 bits wide.
- Separators are space, CR, LF, and ','. A separator with no digits since the last token is skipped and forms no empty token.
- A separator after digits commits the token and clears the accumulator.
- Overflow: any acc value above 2^DATA_W-1 sets a sticky flag. The error is raised when the token is committed.
- Any other byte, including '-' when signed entry is disabled, goes to ERR with code 0.
- ESC (0x1B) in any non-IDLE state goes to ERR with code 3.
- DIM_M / DIM_N: a value of 0 or greater than MAX_DIM goes to ERR with code 2. Otherwise the dimension is latched. DIM_N then goes to ELEMS (mode 00) or COUNT (mode 01).
- ELEMS: each token drives elem_data and elem_we, with elem_idx counting 0..m*n-1. The m*n-th token goes to DONE.
- COUNT: the token is latched into gen_count (low CNT_W bits), then the state goes to DONE.
- IDS: tokens fill op_ids slots 0..NUM_OPS-1. A value of 2^ID_W or more goes to ERR with code 2. The last slot goes to DONE.
- SCALAR: one token drives elem_data with elem_we=1 and elem_idx=0, then the state goes to DONE.
- DONE and ERR each last one cycle, then return to IDLE. Bytes arriving in those cycles are dropped.
- Outputs committed before an error keep their values. Elements already written are not retracted.

## Timing
- A byte sampled at edge k updates the accumulator, latched outputs, elem_we, and the state at edge k.
- done or err is high for the cycle after edge k+1.
- Back-to-back rx_valid on every cycle is supported with no stalls.
- An abort or error mid-command leaves dim_m, dim_n, and op_ids at their last committed values.
- rst_n assertion returns to IDLE immediately, and all outputs go to 0 asynchronously.

## Configuration
- PARSER_SIGNED_EN defined:
  - A '-' is accepted as the first character of an element or scalar token only. A '-' anywhere else is an illegal character.
  - The value is committed in two's complement.
  - The legal range is -2^(DATA_W-1)..2^(DATA_W-1)-1. Values outside it give code 1.
  - Dimensions, count, and IDs stay unsigned.
- PARSER_SIGNED_EN undefined: '-' is always illegal (code 0), and elements are unsigned 0..2^DATA_W-1.

## Test plan
- Mode 00, bytes "2 3 1 2 3 4 5 6\r": elem_we fires 6 times with idx 0..5 and data 1..6; dim_m=2, dim_n=3; done fires once, one cycle after the final '\r' edge.
- Mode 01, "3  4\r\n2 ": the double separator is skipped; dim_m=3, dim_n=4, gen_count=2; done fires.
- Mode 10, NUM_OPS=2, "7,12 ": op_ids={12,7}, done fires. Mode 10 with "16 " and ID_W=4: err fires with code 2.
- Mode 00, "6 2 ": err with code 2 and dim_m unchanged. Mode 11, "300 " with DATA_W=8: err with code 1 and no elem_we.
- Mode 00, "2 2 5 " then ESC: one elem_we (data 5), then err with code 3; busy drops and the next start is accepted.
- With PARSER_SIGNED_EN, mode 11, "-128 ": elem_data=0x80, done fires. "-129 ": err with code 1. "5-3 ": err with code 0.
